// File: rtl/led_pwm_array.sv
// led_pwm_array: multi-channel LED pulse-width modulator.
//
// One prescaler and one global period counter drive every channel. Each
// channel sees the global counter rotated by a fixed phase offset. When
// STAGGER=1, this spreads the rising edges of the channels across the period
// so their peak currents do not coincide.
//
// Duty values are double-buffered. 'store' is a single-cycle strobe with no
// back-pressure: the block always accepts it. On a strobe, every channel
// copies its slice of 'data' into its shadow register. A channel moves its
// shadow into its active register only at its own period boundary (wrap).
// The PWM waveform therefore never changes mid-period.
//
// The all-ones duty code means 100 % on. Every other code d gives d high
// ticks per period, starting at local count 0.

module led_pwm_array #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 1,
    parameter int STAGGER  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data,
    input  logic                      store,
    output logic [CHANNELS-1:0]       out,
    output logic                      period_start,
    output logic                      pending
);

    // A one-cycle prescale still needs a one-bit register to keep widths legal.
    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    logic [PRE_W-1:0]    pre;
    logic                tick;
    logic [WIDTH-1:0]    cnt;
    logic [CHANNELS-1:0] pend_vec;

    // A tick is the last clock of each prescale interval.
    assign tick = (pre == PRE_LAST);

    // Prescaler: count clocks within one PWM tick and wrap on the tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Global period counter: advance once per tick and wrap modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // period_start marks the first cycle of global count 0.
    // pending reports shadow values that are still waiting for a wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_start <= 1'b0;
            pending      <= 1'b0;
        end else begin
            period_start <= tick && (cnt == CNT_LAST);
            pending      <= |pend_vec;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // The phase offset is fixed at elaboration.
        // Integer division matches (g * 2^WIDTH) / CHANNELS exactly.
        localparam int               OFF_INT = (STAGGER != 0) ? (g * (1 << WIDTH)) / CHANNELS : 0;
        localparam logic [WIDTH-1:0] OFF     = OFF_INT[WIDTH-1:0];

        logic [WIDTH-1:0] slice;
        logic [WIDTH-1:0] loc_cnt;
        logic [WIDTH-1:0] loc_next;
        logic [WIDTH-1:0] shadow_q;
        logic [WIDTH-1:0] active_q;
        logic [WIDTH-1:0] shadow_next;
        logic [WIDTH-1:0] active_next;
        logic             pend_q;
        logic             out_q;
        logic             wrap;

        assign slice    = data[g*WIDTH +: WIDTH];
        assign loc_cnt  = cnt + OFF;
        assign loc_next = loc_cnt + WIDTH'(1);
        assign wrap     = tick && (loc_cnt == CNT_LAST);

        // A store that lands on the wrap goes straight to the active register.
        assign shadow_next = store ? slice : shadow_q;
        assign active_next = wrap ? shadow_next : active_q;

        // Shadow/active double buffer, pending flag and registered compare output.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                shadow_q <= '0;
                active_q <= '0;
                pend_q   <= 1'b0;
                out_q    <= 1'b0;
            end else begin
                if (store) begin
                    shadow_q <= slice;
                end
                if (wrap) begin
                    active_q <= shadow_next;
                    pend_q   <= 1'b0;
                end else if (store) begin
                    pend_q   <= 1'b1;
                end
                // Compare against the count this tick moves to.
                // The result is then valid for that whole tick.
                if (tick) begin
                    out_q <= (active_next == CNT_LAST) || (loc_next < active_next);
                end
            end
        end

        assign out[g]      = out_q;
        assign pend_vec[g] = pend_q;
    end

endmodule
